// File: rtl/fifo_sched_pkg.sv
// rtl/fifo_sched_pkg.sv - shared types and constants for the FIFO write-side scheduler
package fifo_sched_pkg;

  // Default FIFO byte width; the ALU payload is two of these.
  localparam int DATA_W = 8;

  // Source encoding used for the src output and the arbiter pointer.
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_RF  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with one-hot grant and accept-driven pointer
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,     // bit 0 = ALU, bit 1 = RF
  input  logic       update_i,  // the granted request was accepted this cycle
  output logic [1:0] gnt_o
);
  import fifo_sched_pkg::*;

  // Pointer names the source preferred when both request.
  logic ptr_q;
  logic ptr_d;

  // Single requester wins outright; a tie goes to the pointed source.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = (ptr_q == SRC_RF) ? 2'b10 : 2'b01;
    end
  end

  // After an accept the preference moves to the source that was not served.
  always_comb begin
    ptr_d = ptr_q;
    if (update_i) begin
      ptr_d = gnt_o[0] ? SRC_RF : SRC_ALU;
    end
  end

  // Pointer register, ALU preferred out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= SRC_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fifo_wr_sched.sv
// rtl/fifo_wr_sched.sv - shares the FIFO write port between ALU (2 bytes, LSB first) and RF (1 byte)
module fifo_wr_sched #(
  parameter int DATA_W = fifo_sched_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  input  logic [2*DATA_W-1:0] alu_data,
  output logic                alu_ready,
  input  logic                rf_valid,
  input  logic [DATA_W-1:0]   rf_data,
  output logic                rf_ready,
  input  logic                full,
  output logic [DATA_W-1:0]   w_data,
  output logic                w_inc,
  output logic                busy,
  output logic                src
);
  import fifo_sched_pkg::*;

  state_e              state_q;
  logic [2*DATA_W-1:0] hold_q;
  logic                src_q;
  logic                busy_q;

  logic [1:0] gnt;
  logic       idle;
  logic       alu_acc;
  logic       rf_acc;

  assign idle = (state_q == IDLE);

  // Requests are only offered to the arbiter outcome while idle; full is not consulted here.
  assign alu_ready = idle && gnt[0];
  assign rf_ready  = idle && gnt[1];
  assign alu_acc   = alu_valid && alu_ready;
  assign rf_acc    = rf_valid && rf_ready;

  rr_arb2 u_arb (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    ({rf_valid, alu_valid}),
    .update_i (alu_acc || rf_acc),
    .gnt_o    (gnt)
  );

  // Write strobe and byte select follow the registered state; full only gates the strobe.
  always_comb begin
    w_inc  = !idle && !full;
    w_data = hold_q[DATA_W-1:0];
    if (state_q == SEND_HI) begin
      w_data = hold_q[2*DATA_W-1:DATA_W];
    end
  end

  assign busy = busy_q;
  assign src  = src_q;

  // Transfer FSM: capture on accept, emit LSB, then MSB for ALU results, stalling while full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      src_q   <= SRC_ALU;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (alu_acc) begin
            hold_q  <= alu_data;
            src_q   <= SRC_ALU;
            state_q <= SEND_LO;
            busy_q  <= 1'b1;
          end else if (rf_acc) begin
            hold_q  <= {{DATA_W{1'b0}}, rf_data};
            src_q   <= SRC_RF;
            state_q <= SEND_LO;
            busy_q  <= 1'b1;
          end
        end
        SEND_LO: begin
          if (!full) begin
            if (src_q == SRC_ALU) begin
              state_q <= SEND_HI;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        SEND_HI: begin
          if (!full) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_sched.sv
// tb/tb_fifo_wr_sched.sv - scoreboard bench for fifo_wr_sched
module tb_fifo_wr_sched;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid;
  logic [2*DW-1:0] alu_data;
  logic          alu_ready;
  logic          rf_valid;
  logic [DW-1:0] rf_data;
  logic          rf_ready;
  logic          full;
  logic [DW-1:0] w_data;
  logic          w_inc;
  logic          busy;
  logic          src;

  always #5 clk = ~clk;

  fifo_wr_sched #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .rf_valid  (rf_valid),
    .rf_data   (rf_data),
    .rf_ready  (rf_ready),
    .full      (full),
    .w_data    (w_data),
    .w_inc     (w_inc),
    .busy      (busy),
    .src       (src)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  log_q[$];
  logic [15:0] alu_stim[$];
  logic [7:0]  rf_stim[$];

  bit rand_mode = 0;
  bit full_rand = 0;
  bit alu_acc   = 0;
  bit rf_acc    = 0;

  // reference model state: bytes still owed by the current transfer, preferred source, last source
  int m_left = 0;
  bit m_ptr  = 0;
  bit m_src  = 0;
  bit m_ga;
  bit m_gr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_log(input string name, input logic [7:0] e[$]);
    chk({name, "_len"}, log_q.size(), e.size());
    for (int i = 0; i < e.size() && i < log_q.size(); i++) chk(name, log_q[i], e[i]);
    log_q.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((alu_stim.size() > 0 || rf_stim.size() > 0 || alu_valid || rf_valid ||
            m_left > 0 || busy || exp_q.size() > 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL wait_idle: got timeout want idle at %0t", $time);
    end
    @(posedge clk);
    #1;
  endtask

  // model: decides grants from the request rules and predicts the byte stream
  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_left = 0;
      m_ptr  = 0;
      m_src  = 0;
      exp_q.delete();
    end else begin
      chk("busy", busy, m_left > 0);
      if (m_left > 0) begin
        chk("w_inc_busy", w_inc, !full);
        chk("ready_busy", {alu_ready, rf_ready}, 2'b00);
        chk("src", src, m_src);
        if (!full) m_left--;
      end else begin
        chk("w_inc_idle", w_inc, 0);
        m_ga = alu_valid && (!rf_valid || m_ptr == 0);
        m_gr = rf_valid && (!alu_valid || m_ptr == 1);
        chk("alu_ready", alu_ready, m_ga);
        chk("rf_ready", rf_ready, m_gr);
        if (m_ga) begin
          exp_q.push_back(alu_data[7:0]);
          exp_q.push_back(alu_data[15:8]);
          m_left = 2;
          m_ptr  = 1;
          m_src  = 0;
        end else if (m_gr) begin
          exp_q.push_back(rf_data);
          m_left = 1;
          m_ptr  = 0;
          m_src  = 1;
        end
      end
    end
  end

  // monitor: every written byte is logged and compared with the scoreboard head
  initial forever begin
    @(negedge clk);
    alu_acc = alu_valid && alu_ready;
    rf_acc  = rf_valid && rf_ready;
    if (!rst && w_inc === 1'b1) begin
      log_q.push_back(w_data);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got %0h want none at %0t", w_data, $time);
      end else begin
        chk("w_data", w_data, exp_q.pop_front());
      end
    end
  end

  // requester drivers: hold data stable until accepted, optionally withdraw in random mode
  initial forever begin
    bit dropped;
    @(posedge clk);
    #1;
    if (!rst) begin
      dropped = 0;
      if (alu_valid && alu_acc) alu_valid = 0;
      else if (alu_valid && rand_mode && $urandom_range(15) == 0) begin alu_valid = 0; dropped = 1; end
      if (!dropped && !alu_valid && alu_stim.size() > 0 && (!rand_mode || $urandom_range(2) == 0)) begin
        alu_data  = alu_stim.pop_front();
        alu_valid = 1;
      end
      dropped = 0;
      if (rf_valid && rf_acc) rf_valid = 0;
      else if (rf_valid && rand_mode && $urandom_range(15) == 0) begin rf_valid = 0; dropped = 1; end
      if (!dropped && !rf_valid && rf_stim.size() > 0 && (!rand_mode || $urandom_range(2) == 0)) begin
        rf_data  = rf_stim.pop_front();
        rf_valid = 1;
      end
      if (full_rand) full = ($urandom_range(3) == 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running want finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] e[$];
    int n;
    rst = 1; alu_valid = 0; rf_valid = 0; full = 0; alu_data = '0; rf_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_w_inc", w_inc, 0);
    chk("rst_src", src, 0);
    chk("rst_ready", {alu_ready, rf_ready}, 2'b00);
    @(posedge clk); #1 rst = 0;

    alu_stim.push_back(16'h12A5);
    wait_idle(50);
    e = {8'hA5, 8'h12};
    chk_log("alu_single", e);

    rf_stim.push_back(8'h3C);
    wait_idle(50);
    e = {8'h3C};
    chk_log("rf_single", e);

    for (int i = 0; i < 4; i++) begin
      alu_stim.push_back(16'h0102 + 16'h0202 * 16'(i));
      rf_stim.push_back(8'hAA + 8'(i));
    end
    wait_idle(100);
    e = {8'h02, 8'h01, 8'hAA, 8'h04, 8'h03, 8'hAB, 8'h06, 8'h05, 8'hAC, 8'h08, 8'h07, 8'hAD};
    chk_log("rr_order", e);

    full = 1;
    alu_stim.push_back(16'h9C7E);
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    chk("stall_busy", busy, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_nowrite", log_q.size(), 0);
    full = 0;
    wait_idle(50);
    e = {8'h7E, 8'h9C};
    chk_log("stall", e);

    rand_mode = 1; full_rand = 1;
    for (int i = 0; i < 80; i++) begin
      alu_stim.push_back(16'($urandom));
      rf_stim.push_back(8'($urandom));
    end
    wait_idle(6000);
    rand_mode = 0; full_rand = 0; full = 0;
    wait_idle(50);
    log_q.delete();

    alu_stim.push_back(16'hBEEF);
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #2;
    chk("msb_pending_inc", w_inc, 1);
    chk("msb_pending_data", w_data, 8'hBE);
    rst = 1;
    #1;
    chk("rst_mid_w_inc", w_inc, 0);
    chk("rst_mid_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    e = {8'hEF};
    chk_log("rst_mid", e);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_sched.md
# fifo_wr_sched

Write-side scheduler for the asynchronous FIFO. It shares the single FIFO write port between two requesters: the ALU, which delivers a 16-bit result, and the register file, which delivers one 8-bit read value. It serialises each ALU result into two bytes, LSB first, and throttles on the FIFO full flag. It runs entirely in the FIFO write-clock domain and drives the FIFO w_data/w_inc inputs directly.

## Interface
- DATA_W, 8, FIFO byte width; ALU payload is 2*DATA_W
- clk  in  1  write-domain clock (same net as FIFO w_clk)
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result pending
- alu_data  in  2*DATA_W  ALU result; held stable while alu_valid && !alu_ready
- alu_ready  out  1  ALU request accepted this cycle
- rf_valid  in  1  register-file read data pending
- rf_data  in  DATA_W  register-file read data; held stable while rf_valid && !rf_ready
- rf_ready  out  1  RF request accepted this cycle
- full  in  1  FIFO full flag (write domain)
- w_data  out  DATA_W  byte to FIFO
- w_inc  out  1  FIFO write strobe; one byte written per cycle high
- busy  out  1  high in any state other than IDLE
- src  out  1  source of the byte in flight: 0 = ALU, 1 = RF

## Operation
- FSM states: IDLE, SEND_LO, SEND_HI.
- IDLE:
  - Arbitrate among valid requesters.
  - Handshake completes when valid && ready; the payload is captured into hold (2*DATA_W) and src is registered.
  - ALU handshake -> SEND_LO. RF handshake -> SEND_LO, with hold[DATA_W-1:0] = rf_data.
- SEND_LO:
  - w_data = hold[DATA_W-1:0]; w_inc = !full.
  - If !full: src = ALU -> SEND_HI; src = RF -> IDLE.
  - If full: stay in SEND_LO; w_inc = 0.
- SEND_HI:
  - w_data = hold[2*DATA_W-1:DATA_W]; w_inc = !full.
  - If !full -> IDLE; if full: stay.
- Arbitration: two-way round-robin.
  - A priority pointer points at the preferred source; reset value is ALU.
  - Single valid: that source is granted.
  - Both valid: the pointed source is granted, and the pointer flips to the other source after each accepted request.
- alu_ready and rf_ready are combinational: high only in IDLE, for the granted source, and never both high in the same cycle.
- Full is checked only when writing. Acceptance in IDLE does not depend on full.
- The two bytes of an ALU result are always written consecutively; no RF byte is interleaved between them.
- w_data is valid whenever busy; its value when not busy is don't-care (drive hold low byte).

## Timing
- Reset values: state IDLE, w_inc 0, alu_ready 0 (combinational, follows valid after reset release), rf_ready 0, busy 0, src 0, hold 0, pointer ALU.
- Reset is asynchronous. Asserting rst mid-transfer forces w_inc low immediately and discards any held byte. A partially written ALU result (LSB only) is not completed.
- Latency with full low throughout:
  - RF: handshake at cycle N, byte written at edge N+1. Two cycles per RF byte.
  - ALU: LSB written at edge N+1, MSB at edge N+2. Three cycles per ALU result.
- w_inc is combinational from the registered state and full. The FIFO samples w_inc/w_data on the same clk edge on which the FSM advances.
- full rising while in SEND_HI stalls with the MSB held. When full falls, the MSB is written on the first edge with full low.
- Requester deassertion of valid before ready is permitted; no request is latched.

## Structure
- Shared package fifo_sched_pkg:
  - state enum (IDLE, SEND_LO, SEND_HI)
  - source constants SRC_ALU = 0, SRC_RF = 1
  - default DATA_W
- Sub-module rr_arb2: two requests in, one-hot grant out, and an update strobe that flips the priority pointer on accept. Arbitration state stays inside it.
- Top level holds the FSM, the hold register, and the output muxing.

## Test plan
- Reset mid SEND_HI (ALU 0xBEEF, LSB written): assert rst -> w_inc 0 the same cycle; after release the FIFO contains only 0xEF, and busy = 0.
- Single ALU request 0x12A5 with full low -> alu_ready at cycle 0, w_inc high on cycles 1–2, FIFO receives 0xA5 then 0x12.
- Single RF request 0x3C -> rf_ready at cycle 0, one w_inc at cycle 1 with w_data 0x3C, busy low at cycle 2.
- ALU and RF valid together out of reset, repeated 4 times (ALU 0x0102.., RF 0xAA..) -> grant order ALU, RF, ALU, RF; FIFO bytes 02 01 AA 04 03 AB...
- full held high for 5 cycles while in SEND_LO -> w_inc 0 throughout, data held; write occurs on the first edge after full drops, and no byte is lost or duplicated.
